lsu: RTL and testbench
======================

# lsu

Load/store unit between the CPU core's data port and the single-port word-addressed data RAM. Accepts one byte/halfword/word request at a time, generates the RAM byte-write strobes and lane-replicated write data, and aligns plus sign/zero-extends read data returned one cycle after the address. Misaligned or reserved-size requests are rejected without touching memory, and the core receives a single-cycle response pulse.

## Interface

- ADDRESS_WIDTH, 14, byte-address width; RAM word address is bits [ADDRESS_WIDTH-1:2]
- DATA_WIDTH, 32, data width; only 32 is supported
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  core request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 halfword, 2 word, 3 reserved
- req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend
- req_addr  input  ADDRESS_WIDTH  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  aligned, extended load data; 0 for stores and errors
- resp_err  output  1  request was misaligned or reserved size; valid with resp_valid
- ram_we  output  4  byte write strobes to RAM
- ram_addr  output  ADDRESS_WIDTH-2  RAM word address (req_addr[ADDRESS_WIDTH-1:2])
- ram_data  output  32  lane-replicated write data
- ram_q  input  32  RAM read word, registered by RAM one cycle after ram_addr

## Operation

- States: IDLE, WAIT, RESP. Reset -> IDLE.
- req_ready = 1 in IDLE and RESP, 0 in WAIT, 0 while rst_n low. Accept = req_valid & req_ready.
- On accept: latch we, size, unsigned, addr[1:0], err; go to WAIT. IDLE/RESP with no accept -> IDLE.
- WAIT -> RESP unconditionally; at this edge register resp_rdata/resp_err from ram_q and latched fields.
- RESP: resp_valid = 1; a new request may be accepted in the same cycle (-> WAIT), else -> IDLE.
- Error when size==3, size==1 & addr[0], or size==2 & addr[1:0]!=0.
- ram_addr = req_addr[ADDRESS_WIDTH-1:2] combinationally at all times (idle reads harmless).
- ram_we (combinational): 0 unless accept & req_we & !error. Byte: 1<<addr[1:0]. Half: 4'b0011 (addr[1]=0) or 4'b1100. Word: 4'b1111.
- ram_data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load format: s = ram_q >> (8*addr[1:0]); byte -> ext(s[7:0]), half -> ext(s[15:0]), word -> ram_q; ext per unsigned.
- Store or error response: resp_rdata = 0. resp_err = 1 only for errors.

## Timing

- Cycle 0: accept; RAM samples ram_addr/ram_we at end of cycle 0.
- Cycle 1 (WAIT): ram_q valid; block registers result at end of cycle.
- Cycle 2 (RESP): resp_valid = 1 with resp_rdata/resp_err; req_ready = 1.
- Fixed latency 2 cycles for loads, stores and errors; peak throughput one request per 2 cycles.
- resp_valid never held more than one cycle; core has no backpressure.
- Reset values: resp_valid 0, resp_rdata 0, resp_err 0, state IDLE; ram_we 0 and req_ready 0 while rst_n low.
- Reset mid-operation (WAIT or RESP): pending response dropped, no resp_valid after release; store accepted in the cycle before reset already committed.
- req_valid during WAIT is ignored (not accepted, no strobes).

## Test plan

- Store word 0xDEADBEEF @0x0010, then load word @0x0010 -> ram_we 4'b1111 in cycle 0; load resp_valid 2 cycles after accept, resp_rdata 0xDEADBEEF, resp_err 0.
- Store byte 0x80 @0x0013, load byte signed/unsigned @0x0013 -> ram_we 4'b1000, ram_data 0x80808080; resp_rdata 0xFFFFFF80 / 0x00000080.
- Store half 0x8001 @0x0022, load half signed @0x0022 -> ram_we 4'b1100; resp_rdata 0xFFFF8001; bytes @0x0020-21 unchanged.
- Load half @0x0031, store word @0x0032, size 3 @0x0040 -> ram_we stays 0; resp_valid with resp_err 1, resp_rdata 0.
- Back-to-back: req_valid held high with 3 loads -> accepts in cycles 0, 2, 4; resp_valid in cycles 2, 4, 6; req_valid in WAIT not accepted.
- Assert rst_n low in WAIT of a load -> no resp_valid after release; outputs 0; next request completes normally.

Source files
------------

// File: rtl/lsu_if.sv
// Load/store unit bus interface.
// Carries both sides of the load/store unit: the core request/response port
// and the word-addressed RAM port.
//   slave  : the load/store unit itself
//   master : the core plus RAM side (testbench or system glue)
// Core side : req_valid/req_ready handshake, req_we, req_size, req_unsigned,
//             req_addr, req_wdata; resp_valid pulse with resp_rdata/resp_err.
// RAM side  : ram_we byte strobes, ram_addr word address, ram_data write
//             data, ram_q read word returned one cycle after ram_addr.
interface lsu_if #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;
  logic [3:0]               ram_we;
  logic [ADDRESS_WIDTH-3:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_data;
  logic [DATA_WIDTH-1:0]    ram_q;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_q,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_q,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_data
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit between the core data port and a single-port,
// word-addressed data RAM with one cycle of read latency.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : lsu_if.slave, core request/response and RAM signals
// One request is in flight at a time. Stores drive byte strobes and
// lane-replicated data in the accept cycle. Loads align and extend ram_q in
// the following cycle. Every request, including rejected ones, gets a single
// response pulse two cycles after it is accepted.
module lsu #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state;
  logic                  r_we_p1;
  logic [1:0]            r_size_p1;
  logic                  r_uns_p1;
  logic [1:0]            r_off_p1;
  logic                  r_err_p1;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;

  logic w_ready;
  logic w_accept;
  logic w_err;

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [DATA_WIDTH-1:0] format_load(
    input logic [DATA_WIDTH-1:0] q,
    input logic [1:0]            size,
    input logic                  uns,
    input logic [1:0]            off
  );
    logic [DATA_WIDTH-1:0] s;
    s = q >> {off, 3'b000};
    case (size)
      2'd0:    return uns ? {24'd0, s[7:0]}  : {{24{s[7]}},  s[7:0]};
      2'd1:    return uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return q;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the store data into every lane it could land in, so the
  // strobes alone select the destination bytes.
  function automatic logic [DATA_WIDTH-1:0] replicate(
    input logic [1:0]            size,
    input logic [DATA_WIDTH-1:0] wdata
  );
    case (size)
      2'd0:    return {4{wdata[7:0]}};
      2'd1:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Ready is suppressed during reset as well as while the RAM read is in flight.
  assign w_ready  = rst_n && (r_state != WAIT);
  assign w_accept = bus.req_valid && w_ready;
  assign w_err    = (bus.req_size == 2'd3) ||
                    ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));

  assign bus.req_ready  = w_ready;
  assign bus.ram_addr   = bus.req_addr[ADDRESS_WIDTH-1:2];
  assign bus.ram_we     = (w_accept && bus.req_we && !w_err) ?
                          lane_strobe(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
  assign bus.ram_data   = replicate(bus.req_size, bus.req_wdata);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

  // ---- p0 -> p1: latch request attributes on accept ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we_p1   <= bus.req_we;
      r_size_p1 <= bus.req_size;
      r_uns_p1  <= bus.req_unsigned;
      r_off_p1  <= bus.req_addr[1:0];
      r_err_p1  <= w_err;
    end
  end

  // ---- p1 -> p2: control FSM; response registered at the WAIT edge ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE, RESP: r_state <= w_accept ? WAIT : IDLE;
        WAIT: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_err_p1;
          r_resp_rdata <= (r_we_p1 || r_err_p1) ? '0 :
                          format_load(bus.ram_q, r_size_p1, r_uns_p1, r_off_p1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32)) bus ();

  lsu #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Word RAM model with one cycle read latency
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_data[8*b +: 8];
    bus.ram_q <= mem[bus.ram_addr];
  end

  // Reference model: a flat byte-addressed memory
  logic [7:0] ref_mem [0:16383];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit m_err(input logic [1:0] sz, input logic [13:0] a);
    if (sz == 2'd3) return 1'b1;
    return (int'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_strobe(input logic we, input logic [1:0] sz, input logic [13:0] a);
    logic [3:0] s;
    s = 4'b0;
    if (!we || m_err(sz, a)) return s;
    for (int i = 0; i < nbytes(sz); i++) s[(int'(a) + i) % 4] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_lanes(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[8*b +: 8] = wd[8*(b % nbytes(sz)) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [13:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
    if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [13:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
  endtask

  // Drives one request and reports what was observed; comparisons live in the tests.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [13:0] a, input logic [31:0] wd,
                       output logic rdy, output logic [3:0] swe, output logic [31:0] sdata,
                       output logic [11:0] saddr, output int lat,
                       output logic [31:0] rd, output logic er);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    #1;
    rdy = bus.req_ready; swe = bus.ram_we; sdata = bus.ram_data; saddr = bus.ram_addr;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1; rd = 32'd0; er = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = c; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 14'h0010; bus.req_wdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
    n_cmp++; if (bus.ram_we !== 4'b0) begin n_fail++; $display("FAIL reset_ram_we got=%b exp=0000", bus.ram_we); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_resp_rdata got=%h exp=0", bus.resp_rdata); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got=%b exp=0", bus.resp_err); end
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word;
    logic rdy, er; logic [3:0] swe; logic [31:0] sd, rd; logic [11:0] sa; int lat;
    issue(1'b1, 2'd2, 1'b0, 14'h0010, 32'hDEAD_BEEF, rdy, swe, sd, sa, lat, rd, er);
    m_store(2'd2, 14'h0010, 32'hDEAD_BEEF);
    n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL word_st_ready got=%b exp=1", rdy); end
    n_cmp++; if (swe !== 4'b1111) begin n_fail++; $display("FAIL word_st_we got=%b exp=1111", swe); end
    n_cmp++; if (sd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_st_data got=%h exp=deadbeef", sd); end
    n_cmp++; if (sa !== 12'h004) begin n_fail++; $display("FAIL word_st_addr got=%h exp=004", sa); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL word_st_latency got=%0d exp=2", lat); end
    n_cmp++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++; $display("FAIL word_st_resp got=%h/%b exp=0/0", rd, er); end
    @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL resp_pulse got=%b exp=0", bus.resp_valid); end
    issue(1'b0, 2'd2, 1'b0, 14'h0010, 32'h0, rdy, swe, sd, sa, lat, rd, er);
    n_cmp++; if (swe !== 4'b0000) begin n_fail++; $display("FAIL word_ld_we got=%b exp=0000", swe); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL word_ld_latency got=%0d exp=2", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_ld_data got=%h exp=deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL word_ld_err got=%b exp=0", er); end
  endtask

  task automatic test_byte;
    logic rdy, er; logic [3:0] swe; logic [31:0] sd, rd; logic [11:0] sa; int lat;
    issue(1'b1, 2'd0, 1'b0, 14'h0013, 32'h1234_5680, rdy, swe, sd, sa, lat, rd, er);
    m_store(2'd0, 14'h0013, 32'h1234_5680);
    n_cmp++; if (swe !== 4'b1000) begin n_fail++; $display("FAIL byte_st_we got=%b exp=1000", swe); end
    n_cmp++; if (sd !== 32'h8080_8080) begin n_fail++; $display("FAIL byte_st_data got=%h exp=80808080", sd); end
    issue(1'b0, 2'd0, 1'b0, 14'h0013, 32'h0, rdy, swe, sd, sa, lat, rd, er);
    n_cmp++; if (rd !== m_load(2'd0, 1'b0, 14'h0013) || lat !== 2)
      begin n_fail++; $display("FAIL byte_ld_signed got=%h lat=%0d exp=%h lat=2", rd, lat, m_load(2'd0, 1'b0, 14'h0013)); end
    issue(1'b0, 2'd0, 1'b1, 14'h0013, 32'h0, rdy, swe, sd, sa, lat, rd, er);
    n_cmp++; if (rd !== m_load(2'd0, 1'b1, 14'h0013))
      begin n_fail++; $display("FAIL byte_ld_unsigned got=%h exp=%h", rd, m_load(2'd0, 1'b1, 14'h0013)); end
  endtask

  task automatic test_half;
    logic rdy, er; logic [3:0] swe; logic [31:0] sd, rd; logic [11:0] sa; int lat;
    issue(1'b1, 2'd2, 1'b0, 14'h0020, 32'h1122_3344, rdy, swe, sd, sa, lat, rd, er);
    m_store(2'd2, 14'h0020, 32'h1122_3344);
    issue(1'b1, 2'd1, 1'b0, 14'h0022, 32'hABCD_8001, rdy, swe, sd, sa, lat, rd, er);
    m_store(2'd1, 14'h0022, 32'hABCD_8001);
    n_cmp++; if (swe !== 4'b1100) begin n_fail++; $display("FAIL half_st_we got=%b exp=1100", swe); end
    n_cmp++; if (sd !== 32'h8001_8001) begin n_fail++; $display("FAIL half_st_data got=%h exp=80018001", sd); end
    issue(1'b0, 2'd1, 1'b0, 14'h0022, 32'h0, rdy, swe, sd, sa, lat, rd, er);
    n_cmp++; if (rd !== m_load(2'd1, 1'b0, 14'h0022))
      begin n_fail++; $display("FAIL half_ld_signed got=%h exp=%h", rd, m_load(2'd1, 1'b0, 14'h0022)); end
    issue(1'b0, 2'd2, 1'b0, 14'h0020, 32'h0, rdy, swe, sd, sa, lat, rd, er);
    n_cmp++; if (rd !== m_load(2'd2, 1'b0, 14'h0020))
      begin n_fail++; $display("FAIL half_neighbours got=%h exp=%h", rd, m_load(2'd2, 1'b0, 14'h0020)); end
    issue(1'b0, 2'd1, 1'b1, 14'h0020, 32'h0, rdy, swe, sd, sa, lat, rd, er);
    n_cmp++; if (rd !== m_load(2'd1, 1'b1, 14'h0020))
      begin n_fail++; $display("FAIL half_ld_low got=%h exp=%h", rd, m_load(2'd1, 1'b1, 14'h0020)); end
  endtask

  task automatic test_errors;
    logic rdy, er; logic [3:0] swe; logic [31:0] sd, rd; logic [11:0] sa; int lat;
    logic        t_we [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  t_sz [4]  = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [13:0] t_ad [4]  = '{14'h0031, 14'h0032, 14'h0040, 14'h0044};
    for (int i = 0; i < 4; i++) begin
      issue(t_we[i], t_sz[i], 1'b0, t_ad[i], 32'hFFFF_FFFF, rdy, swe, sd, sa, lat, rd, er);
      n_cmp++; if (swe !== 4'b0000) begin n_fail++; $display("FAIL err%0d_we got=%b exp=0000", i, swe); end
      n_cmp++; if (lat !== 2 || er !== 1'b1 || rd !== 32'd0)
        begin n_fail++; $display("FAIL err%0d_resp got lat=%0d err=%b rdata=%h exp lat=2 err=1 rdata=0", i, lat, er, rd); end
    end
    issue(1'b0, 2'd2, 1'b0, 14'h0040, 32'h0, rdy, swe, sd, sa, lat, rd, er);
    n_cmp++; if (rd !== m_load(2'd2, 1'b0, 14'h0040))
      begin n_fail++; $display("FAIL err_mem_untouched got=%h exp=%h", rd, m_load(2'd2, 1'b0, 14'h0040)); end
  endtask

  task automatic test_back_to_back;
    logic rdy, er; logic [3:0] swe; logic [31:0] sd, rd; logic [11:0] sa; int lat;
    logic [31:0] exp_q [$];
    for (int i = 0; i < 3; i++) begin
      logic [31:0] w;
      w = $urandom;
      issue(1'b1, 2'd2, 1'b0, 14'(14'h0080 + 4*i), w, rdy, swe, sd, sa, lat, rd, er);
      m_store(2'd2, 14'(14'h0080 + 4*i), w);
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c <= 4) bus.req_addr = 14'(14'h0080 + 4*(c/2));
      #1;
      if (c <= 4) begin
        n_cmp++; if (bus.req_ready !== (c % 2 == 0))
          begin n_fail++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, bus.req_ready, c % 2 == 0); end
      end
      if (c <= 4 && c % 2 == 0) exp_q.push_back(m_load(2'd2, 1'b0, bus.req_addr));
      n_cmp++; if (bus.resp_valid !== (c >= 2 && c % 2 == 0))
        begin n_fail++; $display("FAIL b2b_resp_valid c=%0d got=%b exp=%b", c, bus.resp_valid, c >= 2 && c % 2 == 0); end
      if (c >= 2 && c % 2 == 0) begin
        n_cmp++; if (bus.resp_rdata !== exp_q[0])
          begin n_fail++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, bus.resp_rdata, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      if (c == 4) begin @(posedge clk); #1 bus.req_valid = 1'b0; end
    end
  endtask

  task automatic test_wait_ignored;
    logic rdy, er; logic [3:0] swe; logic [31:0] sd, rd; logic [11:0] sa; int lat;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 14'h0050; bus.req_wdata = 32'hCAFE_F00D;
    #1;
    n_cmp++; if (bus.ram_we !== 4'b1111) begin n_fail++; $display("FAIL wait_accept_we got=%b exp=1111", bus.ram_we); end
    @(negedge clk); #1;
    n_cmp++; if (bus.req_ready !== 1'b0 || bus.ram_we !== 4'b0000)
      begin n_fail++; $display("FAIL wait_ignored got ready=%b we=%b exp ready=0 we=0000", bus.req_ready, bus.ram_we); end
    bus.req_valid = 1'b0;
    m_store(2'd2, 14'h0050, 32'hCAFE_F00D);
    @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0)
      begin n_fail++; $display("FAIL wait_resp got valid=%b err=%b exp valid=1 err=0", bus.resp_valid, bus.resp_err); end
    issue(1'b0, 2'd2, 1'b0, 14'h0050, 32'h0, rdy, swe, sd, sa, lat, rd, er);
    n_cmp++; if (rd !== m_load(2'd2, 1'b0, 14'h0050))
      begin n_fail++; $display("FAIL wait_readback got=%h exp=%h", rd, m_load(2'd2, 1'b0, 14'h0050)); end
  endtask

  task automatic test_reset_mid;
    logic rdy, er; logic [3:0] swe; logic [31:0] sd, rd; logic [11:0] sa; int lat;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 14'h0010;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_wdata = 32'h5555_5555;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0 || bus.ram_we !== 4'b0000)
      begin n_fail++; $display("FAIL rstmid_in_reset got ready=%b we=%b exp 0/0000", bus.req_ready, bus.ram_we); end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0)
        begin n_fail++; $display("FAIL rstmid_quiet c=%0d got valid=%b rdata=%h err=%b exp 0", c, bus.resp_valid, bus.resp_rdata, bus.resp_err); end
    end
    issue(1'b0, 2'd2, 1'b0, 14'h0010, 32'h0, rdy, swe, sd, sa, lat, rd, er);
    n_cmp++; if (lat !== 2 || rd !== m_load(2'd2, 1'b0, 14'h0010))
      begin n_fail++; $display("FAIL rstmid_after got lat=%0d rdata=%h exp lat=2 rdata=%h", lat, rd, m_load(2'd2, 1'b0, 14'h0010)); end
  endtask

  task automatic test_random;
    logic rdy, er; logic [3:0] swe; logic [31:0] sd, rd; logic [11:0] sa; int lat;
    logic we, uns; logic [1:0] sz; logic [13:0] a; logic [31:0] wd;
    logic [31:0] exp_rd; bit exp_er;
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = 14'($urandom_range(0, 63)); wd = $urandom;
      exp_er = m_err(sz, a);
      exp_rd = (we || exp_er) ? 32'd0 : m_load(sz, uns, a);
      issue(we, sz, uns, a, wd, rdy, swe, sd, sa, lat, rd, er);
      if (we && !exp_er) m_store(sz, a, wd);
      n_cmp++; if (swe !== m_strobe(we, sz, a) || sa !== a[13:2])
        begin n_fail++; $display("FAIL rnd%0d_ram got we=%b addr=%h exp we=%b addr=%h", n, swe, sa, m_strobe(we, sz, a), a[13:2]); end
      if (we && sz != 2'd3) begin
        n_cmp++; if (sd !== m_lanes(sz, wd))
          begin n_fail++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, sd, m_lanes(sz, wd)); end
      end
      n_cmp++; if (lat !== 2 || rd !== exp_rd || er !== exp_er)
        begin n_fail++; $display("FAIL rnd%0d_resp got lat=%0d rdata=%h err=%b exp lat=2 rdata=%h err=%b", n, lat, rd, er, exp_rd, exp_er); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 8'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_wait_ignored();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
